note_scheduler: RTL and testbench

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/note_scheduler.sv | 132 +++++++++++++
 tb/tb_note_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_scheduler.sv
// Keyboard-to-tone note scheduler: detects new key bytes, queues their tone
// divisors in a small FIFO and plays each note for NOTE_LEN cycles followed by GAP_LEN silent cycles.
module note_scheduler #(
    parameter int NOTE_LEN = 25_000_000,
    parameter int GAP_LEN  = 2_500_000,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        data_valid,
    output logic [18:0] divisor,
    output logic        tone_en,
    output logic        retrig,
    output logic        busy,
    output logic        drop
);
    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [24:0]      NOTE_LAST = 25'(NOTE_LEN - 1);
    localparam logic [24:0]      GAP_LAST  = 25'(GAP_LEN - 1);
    localparam logic [24:0]      CNT_ONE   = 25'd1;
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   FCNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_e;

    state_e           state_q, state_d;
    logic [24:0]      cnt_q, cnt_d;
    logic             prev_dv_q;
    logic [18:0]      div_q, div_d;
    logic             drop_q, drop_d;
    logic [18:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic        new_byte, mapped, room, push, pop, fifo_empty;
    logic [18:0] key_div;

    // Key map: home-row letters, lowercase only.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        mapped  = 1'b1;
        key_div = '0;
        case (data)
            "a":     key_div = 19'd191110;
            "s":     key_div = 19'd170265;
            "d":     key_div = 19'd151685;
            "f":     key_div = 19'd143172;
            "g":     key_div = 19'd127551;
            "h":     key_div = 19'd113636;
            "j":     key_div = 19'd101239;
            "k":     key_div = 19'd95555;
            default: mapped = 1'b0;
        endcase
    end

    assign fifo_empty = (count_q == '0);
    assign new_byte   = data_valid & ~prev_dv_q;
    // A pop in the same cycle frees the slot the push needs.
    assign room       = (count_q != FULL_CNT) | pop;
    assign push       = new_byte & mapped & room;
    assign drop_d     = new_byte & ~(mapped & room);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + FCNT_ONE;
            2'b01:   count_d = count_q - FCNT_ONE;
            default: count_d = count_q;
        endcase
        div_d = pop ? mem_q[rd_ptr_q] : div_q;
    end

    // State register plus the datapath registers that share its reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            prev_dv_q <= 1'b1;
            div_q     <= '0;
            drop_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_dv_q <= data_valid;
            div_q     <= div_d;
            drop_q    <= drop_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // NOTE: FIFO storage is not reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= key_div;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!fifo_empty) state_d = LOAD;
            LOAD:    state_d = PLAY;
            PLAY:    if (cnt_q == NOTE_LAST) state_d = GAP;
            GAP:     if (cnt_q == GAP_LAST) state_d = fifo_empty ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Counter restarts on every state change and idles at zero.
    assign cnt_d = ((state_d != state_q) || (state_q == IDLE)) ? '0 : cnt_q + CNT_ONE;

    always_comb begin
        tone_en = (state_q == PLAY);
        retrig  = (state_q == LOAD);
        pop     = (state_q == LOAD);
        busy    = (state_q != IDLE) || !fifo_empty;
    end

    assign divisor = div_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: directed scenarios plus random key traffic, checked
// every cycle against a time-based schedule model (note start cycle + queue).
module tb_note_scheduler;
    localparam int N = 8;
    localparam int G = 3;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data;
    logic        data_valid;
    logic [18:0] divisor;
    logic        tone_en, retrig, busy, drop;

    note_scheduler #(.NOTE_LEN(N), .GAP_LEN(G), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .data_valid (data_valid),
        .divisor    (divisor),
        .tone_en    (tone_en),
        .retrig     (retrig),
        .busy       (busy),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: a note loaded at cycle L sounds on L+1..L+N and the
    // next load may happen no earlier than L+N+G+1.
    int          keymap [byte];
    int          m_q [$];
    longint      cyc = 0;
    longint      load_c = 0;
    bit          loaded_any = 0;
    logic [18:0] m_div = '0;
    bit          m_drop = 0;
    bit          m_prev = 1;

    function automatic bit m_is_load();
        return loaded_any && (cyc == load_c);
    endfunction

    function automatic bit m_tone();
        return loaded_any && (cyc > load_c) && (cyc <= load_c + N);
    endfunction

    function automatic bit m_busy();
        return (loaded_any && (cyc <= load_c + N + G)) || (m_q.size() != 0);
    endfunction

    task automatic model_edge(input bit r, input bit dv, input logic [7:0] d);
        bit is_load, start_load, edge_seen, known, ok;
        if (r) begin
            m_q.delete();
            loaded_any = 0;
            m_div      = '0;
            m_drop     = 0;
            m_prev     = 1;
            cyc++;
            return;
        end
        is_load    = m_is_load();
        start_load = (!loaded_any || (cyc + 1 > load_c + N + G)) && (m_q.size() != 0);
        edge_seen  = dv && !m_prev;
        known      = keymap.exists(d);
        ok         = known && ((m_q.size() - int'(is_load)) < D);
        if (is_load) m_div = 19'(m_q.pop_front());
        if (edge_seen && ok) m_q.push_back(keymap[d]);
        m_drop = edge_seen && !ok;
        m_prev = dv;
        if (start_load) begin
            loaded_any = 1;
            load_c     = cyc + 1;
        end
        cyc++;
    endtask

    int          tone_cnt, retrig_cnt, drop_cnt, first_tone_c, h_cycles;
    logic        prev_tone_obs;
    logic [18:0] note_seq [$];

    task automatic clear_obs();
        tone_cnt     = 0;
        retrig_cnt   = 0;
        drop_cnt     = 0;
        first_tone_c = -1;
        h_cycles     = 0;
        note_seq.delete();
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check mid-cycle.
    task automatic step(input logic r, input logic dv, input logic [7:0] d);
        rst = r;
        data_valid = dv;
        data = d;
        @(posedge clk);
        model_edge(r, dv, d);
        @(negedge clk);
        check("tone_en", 32'(tone_en), 32'(m_tone()));
        check("retrig", 32'(retrig), 32'(m_is_load()));
        check("divisor", 32'(divisor), 32'(m_div));
        check("drop", 32'(drop), 32'(m_drop));
        check("busy", 32'(busy), 32'(m_busy()));
        tone_cnt   += int'(tone_en);
        retrig_cnt += int'(retrig);
        drop_cnt   += int'(drop);
        if (divisor == 19'd113636) h_cycles++;
        if (tone_en && first_tone_c < 0) first_tone_c = int'(cyc);
        if (tone_en && !prev_tone_obs) note_seq.push_back(divisor);
        prev_tone_obs = tone_en;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic key(input logic [7:0] d);
        step(1'b0, 1'b1, d);
        step(1'b0, 1'b0, d);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        clear_obs();
    endtask

    logic [7:0] keys [8];
    int         edge_c;
    bit         found;

    initial begin
        keys = '{"a", "s", "d", "f", "g", "h", "j", "k"};
        keymap["a"] = 191110; keymap["s"] = 170265; keymap["d"] = 151685; keymap["f"] = 143172;
        keymap["g"] = 127551; keymap["h"] = 113636; keymap["j"] = 101239; keymap["k"] = 95555;
        prev_tone_obs = 1'b0;
        clear_obs();

        // Reset state, with data_valid high across release: no byte.
        step(1'b1, 1'b1, "a");
        step(1'b1, 1'b1, "a");
        check("rst_divisor", 32'(divisor), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step(1'b0, 1'b1, "a");
        step(1'b0, 1'b1, "a");
        idle(15);
        check("dv_at_release_notes", 32'(retrig_cnt), 32'd0);

        // Single note timeline.
        do_reset();
        edge_c = int'(cyc) + 1;
        key("a");
        idle(14);
        check("single_first_tone_latency", 32'(first_tone_c - edge_c), 32'd2);
        check("single_tone_cycles", 32'(tone_cnt), 32'd8);
        check("single_retrig_count", 32'(retrig_cnt), 32'd1);
        check("single_end_busy", 32'(busy), 32'd0);

        // Three notes queued during the first one.
        do_reset();
        key("a"); key("s"); key("d");
        idle(45);
        check("seq_count", 32'(note_seq.size()), 32'd3);
        if (note_seq.size() == 3) begin
            check("seq_note0", 32'(note_seq[0]), 32'd191110);
            check("seq_note1", 32'(note_seq[1]), 32'd170265);
            check("seq_note2", 32'(note_seq[2]), 32'd151685);
        end
        check("seq_tone_cycles", 32'(tone_cnt), 32'd24);

        // Unmapped bytes.
        do_reset();
        key("z"); key("A");
        idle(5);
        check("unmapped_drops", 32'(drop_cnt), 32'd2);
        check("unmapped_tone", 32'(tone_cnt), 32'd0);

        // Full FIFO: 5th key dropped, then a key on the LOAD cycle is accepted.
        do_reset();
        key("a"); key("s"); key("d"); key("f"); key("g"); key("h");
        check("full_drop_count", 32'(drop_cnt), 32'd1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_is_load() && m_q.size() == D) found = 1;
            else step(1'b0, 1'b0, 8'h00);
        end
        check("full_load_wait", 32'(found), 32'd1);
        key("j");
        idle(80);
        check("full_notes_played", 32'(retrig_cnt), 32'd6);
        check("full_drops_total", 32'(drop_cnt), 32'd1);
        check("full_dropped_never_loaded", 32'(h_cycles), 32'd0);

        // data_valid held high.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, "f");
        idle(20);
        check("hold_notes", 32'(retrig_cnt), 32'd1);
        check("hold_divisor", 32'(divisor), 32'd143172);
        check("hold_tone_cycles", 32'(tone_cnt), 32'd8);

        // Reset in the middle of a note with two queued.
        do_reset();
        key("a"); key("s"); key("d");
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_tone() && cyc == load_c + 4) found = 1;
            else step(1'b0, 1'b0, 8'h00);
        end
        check("midplay_wait", 32'(found), 32'd1);
        step(1'b1, 1'b0, 8'h00);
        check("midplay_tone_off", 32'(tone_en), 32'd0);
        check("midplay_busy_off", 32'(busy), 32'd0);
        clear_obs();
        idle(30);
        check("midplay_no_more_notes", 32'(retrig_cnt), 32'd0);

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : keys[$urandom_range(0, 7)];
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0), d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
